// File: rtl/systolic_scheduler.sv
// Operand fetch / skew / issue sequencer for an N x N systolic array.
// Optional SA_SCHED_PERF_CNT_EN adds a saturating WAIT_PE stall-cycle counter.
module systolic_scheduler #(
  parameter int N  = 4,
  parameter int KW = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [KW-1:0]   cmd_k,
  output logic            op_req,
  output logic [KW-1:0]   op_idx,
  input  logic            op_valid,
  input  logic [N*32-1:0] op_x,
  input  logic [N*32-1:0] op_w,
  output logic [N*32-1:0] x_feed,
  output logic [N*32-1:0] w_feed,
  output logic            pe_start,
  input  logic            pe_stall_any,
  input  logic            pe_ready_all,
  output logic            busy,
  output logic            done
`ifdef SA_SCHED_PERF_CNT_EN
  ,output logic [31:0]    stall_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_PE, DRAIN, DONE} state_t;

  localparam int DW = (N > 1) ? $clog2(2*N) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(2*(N-1));

  state_t        r_state, w_nxt;
  logic [KW-1:0] r_k, r_cmdk;
  logic [DW-1:0] r_dcnt;
  logic          r_drain;
  logic          r_cmd_ready, r_op_req, r_pe_start, r_busy, r_done;
  logic [KW:0]   w_kinc;
  logic          w_accept, w_adv, w_last, w_load, w_dshift, w_shift, w_clr;

  // k+1 is formed one bit wider so cmd_k = 2^KW-1 terminates without wrap
  assign w_kinc   = {1'b0, r_k} + (KW+1)'(1);
  assign w_last   = (w_kinc >= {1'b0, r_cmdk});
  assign w_accept = (r_state == IDLE) && cmd_valid;
  assign w_adv    = (r_state == WAIT_PE) && !pe_stall_any && pe_ready_all;
  assign w_load   = (r_state == FETCH) && op_valid;
  assign w_dshift = (r_state == DRAIN) && (r_dcnt != '0);
  assign w_shift  = w_load || w_dshift;
  assign w_clr    = w_accept || (r_state == DONE);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_nxt = (cmd_k == '0) ? DONE : FETCH;
      FETCH:   if (op_valid) w_nxt = ISSUE;
      ISSUE:   w_nxt = WAIT_PE;
      WAIT_PE: if (w_adv) begin
                 if (r_drain)                w_nxt = DRAIN;
                 else if (!w_last)           w_nxt = FETCH;
                 else if (DRAIN_INIT == '0)  w_nxt = DONE;
                 else                        w_nxt = DRAIN;
               end
      DRAIN:   w_nxt = (r_dcnt == '0) ? DONE : ISSUE;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_op_req    <= 1'b0;
      r_pe_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_cmd_ready <= (w_nxt == IDLE);
      r_op_req    <= (w_nxt == FETCH);
      r_pe_start  <= (w_nxt == ISSUE);
      r_busy      <= (w_nxt != IDLE);
      r_done      <= (w_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_k     <= '0;
      r_cmdk  <= '0;
      r_dcnt  <= '0;
      r_drain <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmdk  <= cmd_k;
        r_k     <= '0;
        r_drain <= 1'b0;
      end
      if (w_adv && !r_drain) begin
        r_k <= w_kinc[KW-1:0];
        if (w_last) begin
          r_dcnt  <= DRAIN_INIT;
          r_drain <= 1'b1;
        end
      end
      if (w_dshift) r_dcnt <= r_dcnt - 1'b1;
    end
  end

  // Lane i is an (i+1)-deep chain; all chains advance together on each issue step
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [31:0] r_cx [0:i];
    logic [31:0] r_cw [0:i];
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        for (int unsigned j = 0; j <= i; j++) begin
          r_cx[j] <= '0;
          r_cw[j] <= '0;
        end
      end else if (w_clr) begin
        for (int unsigned j = 0; j <= i; j++) begin
          r_cx[j] <= '0;
          r_cw[j] <= '0;
        end
      end else if (w_shift) begin
        r_cx[0] <= w_load ? op_x[32*i +: 32] : '0;
        r_cw[0] <= w_load ? op_w[32*i +: 32] : '0;
        for (int unsigned j = 1; j <= i; j++) begin
          r_cx[j] <= r_cx[j-1];
          r_cw[j] <= r_cw[j-1];
        end
      end
    end
    assign x_feed[32*i +: 32] = r_cx[i];
    assign w_feed[32*i +: 32] = r_cw[i];
  end

`ifdef SA_SCHED_PERF_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                     r_stall <= '0;
    else if (w_accept)                              r_stall <= '0;
    else if ((r_state == WAIT_PE) && !w_adv && (r_stall != '1)) r_stall <= r_stall + 1'b1;
  end
  assign stall_cycles = r_stall;
`endif

  assign cmd_ready = r_cmd_ready;
  assign op_req    = r_op_req;
  assign op_idx    = r_k;
  assign pe_start  = r_pe_start;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
